q_update_engine: RTL and testbench

Sequencing and arithmetic stage for the tic-tac-toe Q-learning accelerator; it sits downstream of the nine per-action Q-value RAMs and upstream of their decoder write port. On each `start` it scans the nine Q entries of `next_state` for the maximum value and greedy action. It then reads Q(`state`, `action`) and computes Q + α·(r + γ·maxQ − Q) in signed 8-bit fixed point. Finally it writes the saturated result back through the action-select decoder.

---
 rtl/q_update_engine_if.sv | 41 ++++
 rtl/q_update_engine.sv | 191 +++++++++++++++++++
 tb/tb_q_update_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/q_update_engine_if.sv
// Port bundle for q_update_engine: request/result signals plus the Q-RAM
// read port and the decoder write port.
interface q_update_engine_if;
  logic        start;
  logic [17:0] state;
  logic [17:0] next_state;
  logic [3:0]  action;
  logic        terminal;
  logic [7:0]  reward;
  logic [7:0]  gamma;
  logic [7:0]  alfa;

  logic [3:0]  rd_sel;
  logic [17:0] read_address;
  logic [7:0]  rd_data;

  logic [3:0]  sel;
  logic [17:0] write_address;
  logic [7:0]  d_in;

  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  Q;
  logic [7:0]  max_q;
  logic [3:0]  best_action;

  modport slave (
    input  start, state, next_state, action, terminal, reward, gamma, alfa,
    input  rd_data,
    output rd_sel, read_address, sel, write_address, d_in,
    output busy, done, err, Q, max_q, best_action
  );

  modport master (
    output start, state, next_state, action, terminal, reward, gamma, alfa,
    output rd_data,
    input  rd_sel, read_address, sel, write_address, d_in,
    input  busy, done, err, Q, max_q, best_action
  );
endinterface

// File: rtl/q_update_engine.sv
// Q-learning update stage: scans Q(next_state, 1..9) for max/argmax, reads
// Q(state, action), computes Q + a*(r + g*maxQ - Q) and writes it back saturated.
module q_update_engine (
  input  logic              clock,
  input  logic              reset_n,
  q_update_engine_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SCAN, READ_CUR, WAIT_CUR, CALC, WRITE} fsm_t;

  localparam int W = 26;

  fsm_t               fsm;
  logic [3:0]         k;
  logic [3:0]         act;
  logic [3:0]         best;
  logic [17:0]        cur_addr;
  logic               term;
  logic signed [7:0]  rew;
  logic [7:0]         gam;
  logic [7:0]         alf;
  logic signed [7:0]  run_max;
  logic signed [7:0]  q_old;

  logic [3:0]         rd_sel;
  logic [17:0]        read_address;
  logic [3:0]         sel;
  logic [17:0]        write_address;
  logic [7:0]         d_in;
  logic               busy;
  logic               done;
  logic               err;
  logic [7:0]         q_out;
  logic [7:0]         max_q;
  logic [3:0]         best_action;

  // One wide signed datapath; every intermediate fits, so the result equals the
  // narrow 9/10/11-bit formulation while floor-shifts stay exact.
  logic signed [W-1:0] g_prod;
  logic signed [W-1:0] g_sh;
  logic signed [W-1:0] target;
  logic signed [W-1:0] td;
  logic signed [W-1:0] d_prod;
  logic signed [W-1:0] d_sh;
  logic signed [W-1:0] q_sum;
  logic signed [W-1:0] q_old_ext;
  logic [7:0]          q_new;
  logic signed [7:0]   rd_val;

  assign rd_val    = $signed(bus.rd_data);
  assign q_old_ext = $signed({{18{q_old[7]}}, q_old});
  assign g_prod    = $signed({18'd0, gam}) * $signed({{18{run_max[7]}}, run_max});
  assign g_sh      = g_prod >>> 8;
  assign target    = g_sh + $signed({{18{rew[7]}}, rew});
  assign td        = target - q_old_ext;
  assign d_prod    = $signed({18'd0, alf}) * td;
  assign d_sh      = d_prod >>> 8;
  assign q_sum     = d_sh + q_old_ext;

  always_comb begin
    q_new = q_sum[7:0];
    if (q_sum > 26'sd127)
      q_new = 8'h7f;
    else if (q_sum < -26'sd128)
      q_new = 8'h80;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm           <= IDLE;
      k             <= 4'd0;
      act           <= 4'd0;
      best          <= 4'd0;
      cur_addr      <= 18'd0;
      term          <= 1'b0;
      rew           <= 8'sd0;
      gam           <= 8'd0;
      alf           <= 8'd0;
      run_max       <= 8'sd0;
      q_old         <= 8'sd0;
      rd_sel        <= 4'd0;
      read_address  <= 18'd0;
      sel           <= 4'd0;
      write_address <= 18'd0;
      d_in          <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      q_out         <= 8'd0;
      max_q         <= 8'd0;
      best_action   <= 4'd0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (bus.start) begin
            act      <= bus.action;
            cur_addr <= bus.state;
            term     <= bus.terminal;
            rew      <= $signed(bus.reward);
            gam      <= bus.gamma;
            alf      <= bus.alfa;
            if (bus.action == 4'd0 || bus.action > 4'd9) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (bus.terminal) begin
              fsm          <= READ_CUR;
              busy         <= 1'b1;
              rd_sel       <= bus.action;
              read_address <= bus.state;
              run_max      <= 8'sd0;
              best         <= 4'd0;
            end else begin
              fsm          <= SCAN;
              busy         <= 1'b1;
              k            <= 4'd1;
              rd_sel       <= 4'd1;
              read_address <= bus.next_state;
              run_max      <= -8'sd128;
              best         <= 4'd0;
            end
          end
        end

        SCAN: begin
          // Data arriving now belongs to read k-1; strict > keeps the lowest index on ties.
          if (k != 4'd1 && rd_val > run_max) begin
            run_max <= rd_val;
            best    <= k - 4'd1;
          end
          if (k == 4'd9) begin
            fsm          <= READ_CUR;
            rd_sel       <= act;
            read_address <= cur_addr;
          end else begin
            k      <= k + 4'd1;
            rd_sel <= k + 4'd1;
          end
        end

        READ_CUR: begin
          if (!term && rd_val > run_max) begin
            run_max <= rd_val;
            best    <= 4'd9;
          end
          rd_sel <= 4'd0;
          fsm    <= WAIT_CUR;
        end

        WAIT_CUR: begin
          q_old <= rd_val;
          fsm   <= CALC;
        end

        CALC: begin
          sel           <= act;
          write_address <= cur_addr;
          d_in          <= q_new;
          done          <= 1'b1;
          q_out         <= q_new;
          max_q         <= run_max;
          best_action   <= best;
          fsm           <= WRITE;
        end

        WRITE: begin
          sel  <= 4'd0;
          done <= 1'b0;
          busy <= 1'b0;
          fsm  <= IDLE;
        end

        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.rd_sel        = rd_sel;
  assign bus.read_address  = read_address;
  assign bus.sel           = sel;
  assign bus.write_address = write_address;
  assign bus.d_in          = d_in;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.err           = err;
  assign bus.Q             = q_out;
  assign bus.max_q         = max_q;
  assign bus.best_action   = best_action;

endmodule

// File: tb/tb_q_update_engine.sv
// Directed bench for q_update_engine: a behavioural Q-RAM model, a driver that
// queues hand-computed expectations, and a monitor that checks each done pulse.
module tb_q_update_engine;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  q_update_engine_if bus();

  q_update_engine dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        err;
    logic [3:0]  sel;
    logic [17:0] wa;
    logic [7:0]  d;
    logic [7:0]  mq;
    logic [3:0]  ba;
    logic [7:0]  q;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int writes = 0;

  logic [7:0] mem [1:9][0:255];
  logic       pl_en = 1'b0;
  logic [3:0] pl_ram = 4'd1;
  logic [7:0] pl_addr = 8'd0;
  logic [7:0] pl_data = 8'd0;

  logic [7:0] last_q = 8'd0;
  logic [7:0] last_mq = 8'd0;
  logic [3:0] last_ba = 4'd0;

  localparam logic [17:0] NS1 = 18'h12310, NS2 = 18'h30020, NS3 = 18'h04530, NS4 = 18'h22240;
  localparam logic [17:0] S1 = 18'h00101, S2 = 18'h10102, S3 = 18'h20103, S4 = 18'h30104;
  localparam logic [17:0] S5 = 18'h01105, S6 = 18'h11106, S7 = 18'h21107, S8 = 18'h31108;
  localparam logic [17:0] S9 = 18'h02109;

  always @(posedge clock) cyc <= cyc + 1;

  // Q-RAM array: registered read from the selected RAM, write through the decoder.
  always @(posedge clock) begin
    if (bus.rd_sel >= 4'd1 && bus.rd_sel <= 4'd9)
      bus.rd_data <= mem[bus.rd_sel][bus.read_address[7:0]];
    else
      bus.rd_data <= 8'h00;
    if (bus.sel != 4'd0)
      writes <= writes + 1;
    if (bus.sel >= 4'd1 && bus.sel <= 4'd9)
      mem[bus.sel][bus.write_address[7:0]] <= bus.d_in;
    else if (pl_en)
      mem[pl_ram][pl_addr] <= pl_data;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.err && !bus.done) begin
      total++; bad++;
      $display("FAIL err_without_done at t=%0t", $time);
    end
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: sel=%0h d_in=%0h at t=%0t", bus.sel, bus.d_in, $time);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.t0, e.lat);
        chk("err", {31'd0, bus.err}, {31'd0, e.err});
        chk("sel", {28'd0, bus.sel}, {28'd0, e.sel});
        chk("busy", {31'd0, bus.busy}, {31'd0, ~e.err});
        chk("Q", {24'd0, bus.Q}, {24'd0, e.q});
        chk("max_q", {24'd0, bus.max_q}, {24'd0, e.mq});
        chk("best_action", {28'd0, bus.best_action}, {28'd0, e.ba});
        if (e.err) begin
          chk("rd_sel_idle", {28'd0, bus.rd_sel}, 32'd0);
        end else begin
          chk("write_address", {14'd0, bus.write_address}, {14'd0, e.wa});
          chk("d_in", {24'd0, bus.d_in}, {24'd0, e.d});
        end
        $display("txn sel=%0d wa=%05h d_in=%02h max_q=%02h best=%0d err=%0b lat=%0d",
                 bus.sel, bus.write_address, bus.d_in, bus.max_q, bus.best_action, bus.err, cyc - e.t0);
      end
    end
  end

  task automatic preload(input logic [3:0] r, input logic [7:0] a, input logic [7:0] d);
    pl_ram = r; pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic [3:0] a, input logic [17:0] s, input logic [17:0] ns,
                       input logic t, input logic [7:0] r, input logic [7:0] g, input logic [7:0] al);
    bus.action = a; bus.state = s; bus.next_state = ns; bus.terminal = t;
    bus.reward = r; bus.gamma = g; bus.alfa = al; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Called right after a negedge so the start is sampled on the next rising edge.
  task automatic issue(input logic [3:0] a, input logic [17:0] s, input logic [17:0] ns,
                       input logic t, input logic [7:0] r, input logic [7:0] g, input logic [7:0] al,
                       input logic [7:0] xd, input logic [7:0] xmq, input logic [3:0] xba, input int lat);
    exp_t x;
    logic legal;
    legal = (a >= 4'd1 && a <= 4'd9);
    x.err = ~legal;
    x.sel = legal ? a : 4'd0;
    x.wa  = s;
    x.d   = xd;
    x.mq  = legal ? xmq : last_mq;
    x.ba  = legal ? xba : last_ba;
    x.q   = legal ? xd : last_q;
    x.lat = lat;
    x.t0  = cyc;
    if (legal) begin
      last_q = xd; last_mq = xmq; last_ba = xba;
    end
    sb.push_back(x);
    drive(a, s, ns, t, r, g, al);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: %0d pending", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_sel"}, {28'd0, bus.sel}, 32'd0);
    chk({tag, "_rd_sel"}, {28'd0, bus.rd_sel}, 32'd0);
    chk({tag, "_read_address"}, {14'd0, bus.read_address}, 32'd0);
    chk({tag, "_Q"}, {24'd0, bus.Q}, 32'd0);
    chk({tag, "_max_q"}, {24'd0, bus.max_q}, 32'd0);
    chk({tag, "_best_action"}, {28'd0, bus.best_action}, 32'd0);
    chk({tag, "_d_in"}, {24'd0, bus.d_in}, 32'd0);
  endtask

  logic [7:0] ns1_q [1:9];
  logic [7:0] ns3_q [1:9];
  int w0;

  initial begin
    bus.start = 1'b0; bus.action = 4'd0; bus.state = 18'd0; bus.next_state = 18'd0;
    bus.terminal = 1'b0; bus.reward = 8'd0; bus.gamma = 8'd0; bus.alfa = 8'd0;
    ns1_q = '{8'd5, 8'd100, 8'd3, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ns3_q = '{8'hFB, 8'hFD, 8'hFD, 8'h9C, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};

    @(negedge clock);
    for (int r = 1; r <= 9; r++) begin
      preload(r[3:0], NS1[7:0], ns1_q[r]);
      preload(r[3:0], NS2[7:0], 8'h7F);
      preload(r[3:0], NS3[7:0], ns3_q[r]);
      preload(r[3:0], NS4[7:0], 8'h80);
    end
    preload(4'd4, S1[7:0], 8'h00);
    preload(4'd7, S2[7:0], 8'h78);
    preload(4'd3, S3[7:0], 8'h0A);
    preload(4'd5, S4[7:0], 8'h00);
    preload(4'd9, S5[7:0], 8'h88);
    preload(4'd1, S6[7:0], 8'h14);
    preload(4'd6, S7[7:0], 8'h00);
    preload(4'd4, S8[7:0], 8'h00);
    preload(4'd8, S9[7:0], 8'hF6);

    chk_zero_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Basic update with a tie at actions 2 and 4.
    issue(4'd4, S1, NS1, 1'b0, 8'd64, 8'd128, 8'd128, 8'h39, 8'h64, 4'd2, 13);
    wait_idle();
    // Positive saturation.
    issue(4'd7, S2, NS2, 1'b0, 8'd127, 8'd255, 8'd255, 8'h7F, 8'h7F, 4'd1, 13);
    wait_idle();
    // Terminal with negative reward.
    issue(4'd3, S3, NS1, 1'b1, 8'h9C, 8'd200, 8'd128, 8'hD3, 8'h00, 4'd0, 4);
    wait_idle();
    // Illegal actions leave results untouched.
    issue(4'd0, S1, NS1, 1'b0, 8'd10, 8'd10, 8'd10, 8'h00, 8'h00, 4'd0, 1);
    wait_idle();
    issue(4'd10, S1, NS1, 1'b0, 8'd10, 8'd10, 8'd10, 8'h00, 8'h00, 4'd0, 1);
    wait_idle();
    // Negative Q values: signed compare and floor rounding.
    issue(4'd5, S4, NS3, 1'b0, 8'd0, 8'd128, 8'd128, 8'hFF, 8'hFD, 4'd2, 13);
    wait_idle();
    // All -128: no strict winner, and negative saturation.
    issue(4'd9, S5, NS4, 1'b0, 8'h80, 8'd255, 8'd255, 8'h80, 8'h80, 4'd0, 13);
    wait_idle();

    // Start while busy must be dropped.
    w0 = writes;
    issue(4'd1, S6, NS1, 1'b0, 8'd10, 8'd64, 8'd64, 8'h17, 8'h64, 4'd2, 13);
    repeat (4) @(negedge clock);
    drive(4'd2, S9, NS2, 1'b1, 8'd1, 8'd1, 8'd1);
    wait_idle();
    chk("single_write", writes - w0, 1);
    issue(4'd6, S7, NS1, 1'b1, 8'd50, 8'd0, 8'd255, 8'h31, 8'h00, 4'd0, 4);
    wait_idle();

    // Asynchronous reset during SCAN cycle 7.
    w0 = writes;
    drive(4'd4, S8, NS1, 1'b0, 8'd20, 8'd128, 8'd128);
    repeat (6) @(negedge clock);
    chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    last_q = 8'd0; last_mq = 8'd0; last_ba = 4'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("reset_no_write", writes - w0, 0);
    chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);
    issue(4'd8, S9, NS1, 1'b1, 8'd0, 8'd0, 8'd128, 8'hFB, 8'h00, 4'd0, 4);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_expired");
    $fatal(1);
  end

endmodule
